// File: rtl/ysyx_exu_pkg.sv
// Shared types for the completion-queue EXU: op kinds, ALU op codes and the queue entry layout.
// Entry fields are sized by CQ_XLEN/CQ_RW; the top's XLEN/RW parameters default to these.
package ysyx_exu_pkg;

  localparam int CQ_XLEN = 32;
  localparam int CQ_RW   = 4;

  typedef enum logic [2:0] {
    ALU    = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    BRANCH = 3'd3,
    JUMP   = 3'd4
  } kind_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_SLE  = 4'd10;
  localparam logic [3:0] ALU_SLEU = 4'd11;

  typedef struct packed {
    logic [CQ_XLEN-1:0] pc;
    logic [CQ_RW-1:0]   rd;
    kind_t              kind;
    logic [CQ_XLEN-1:0] addr;
    logic [CQ_XLEN-1:0] wdata;
    logic [2:0]         funct3;
    logic [CQ_XLEN-1:0] result;
    logic               done;
  } cq_entry_t;

  function automatic logic is_mem(input kind_t k);
    return (k == LOAD) || (k == STORE);
  endfunction

endpackage

// File: rtl/ysyx_exu_cq_alu.sv
// Combinational XLEN-wide ALU with branch-taken decode for the issue stage.
module ysyx_exu_cq_alu import ysyx_exu_pkg::*; #(
  parameter int XLEN = CQ_XLEN
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      op,
  output logic [XLEN-1:0] res,
  output logic            taken
);

  localparam int SW = $clog2(XLEN);

  logic [SW-1:0] sh;
  assign sh = b[SW-1:0];

  always_comb begin
    res = '0;
    case (op)
      ALU_ADD:  res = a + b;
      ALU_SUB:  res = a - b;
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_XOR:  res = a ^ b;
      ALU_SLL:  res = a << sh;
      ALU_SRL:  res = a >> sh;
      ALU_SRA:  res = XLEN'($signed(a) >>> sh);
      ALU_SLT:  res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: res = {{(XLEN-1){1'b0}}, a < b};
      ALU_SLE:  res = {{(XLEN-1){1'b0}}, $signed(a) <= $signed(b)};
      ALU_SLEU: res = {{(XLEN-1){1'b0}}, a <= b};
      default:  res = '0;
    endcase
  end

  // SUB encodes equality branches; the compare ops encode their condition as a nonzero result
  always_comb begin
    taken = 1'b0;
    case (op)
      ALU_SUB:                                      taken = (res == '0);
      ALU_XOR, ALU_SLT, ALU_SLTU, ALU_SLE, ALU_SLEU: taken = (res != '0);
      default:                                      taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ysyx_exu_cq.sv
// In-order completion-queue EXU: ALU/branch resolve at issue, memory ops serialised to the LSU.
// Optional perf counters are enabled with `define YSYX_EXU_PERF_EN.
module ysyx_exu_cq import ysyx_exu_pkg::*; #(
  parameter int XLEN  = CQ_XLEN,
  parameter int DEPTH = 4,
  parameter int RW    = CQ_RW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  kind_t           in_kind,
  input  logic [3:0]      in_alu_op,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic [XLEN-1:0] in_opj,
  input  logic [XLEN-1:0] in_imm,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_pnpc,
  input  logic [RW-1:0]   in_rd,
  output logic            lsu_avalid_o,
  output logic            lsu_wen_o,
  output logic [XLEN-1:0] lsu_addr_o,
  output logic [XLEN-1:0] lsu_wdata_o,
  output logic [2:0]      lsu_funct3_o,
  input  logic [XLEN-1:0] lsu_rdata_i,
  input  logic            lsu_rvalid_i,
  input  logic            lsu_wready_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_wdata,
  output logic [RW-1:0]   out_rd,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o
`ifdef YSYX_EXU_PERF_EN
  ,
  output logic [31:0]     perf_retire_o,
  output logic [31:0]     perf_mispred_o,
  output logic [31:0]     perf_lsu_wait_o
`endif
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_REQ} lsu_state_t;

  cq_entry_t       q [DEPTH];
  logic [PW-1:0]   head, tail, lsu_ptr;
  logic [PW:0]     count, lsu_pend;
  lsu_state_t      lsu_state, lsu_state_nx;
  logic            redir_q;
  logic [XLEN-1:0] redir_pc_q;

  logic [XLEN-1:0] alu_res, ea, seq_pc, actual;
  logic            alu_taken, push, pop, mispred;
  logic            lsu_done, lsu_skip, lsu_adv;
  cq_entry_t       new_entry, cur;

  ysyx_exu_cq_alu #(.XLEN(XLEN)) u_alu (
    .a     (in_src1),
    .b     (in_src2),
    .op    (in_alu_op),
    .res   (alu_res),
    .taken (alu_taken)
  );

  assign in_ready = (count < (PW+1)'(DEPTH)) & ~redir_q;
  assign push     = in_valid & in_ready;
  assign out_valid = (count != '0) & q[head].done;
  assign pop      = out_valid & out_ready;

  assign ea     = in_opj + in_imm;
  assign seq_pc = in_pc + XLEN'(4);

  always_comb begin
    actual  = seq_pc;
    mispred = 1'b0;
    if (in_kind == BRANCH) actual = alu_taken ? ea : seq_pc;
    else if (in_kind == JUMP) actual = ea;
    if (push && (in_kind == BRANCH || in_kind == JUMP)) mispred = (actual != in_pnpc);
  end

  always_comb begin
    new_entry        = '0;
    new_entry.pc     = in_pc;
    new_entry.rd     = in_rd;
    new_entry.kind   = in_kind;
    new_entry.addr   = ea;
    new_entry.wdata  = in_src2;
    new_entry.funct3 = in_funct3;
    new_entry.done   = ~is_mem(in_kind);
    if (in_kind == ALU) new_entry.result = alu_res;
    else if (in_kind == JUMP) new_entry.result = seq_pc;
  end

  // lsu_pend counts entries from lsu_ptr up to the tail, which disambiguates ptr==tail
  assign cur      = q[lsu_ptr];
  assign lsu_done = (lsu_state == S_REQ) & ((cur.kind == STORE) ? lsu_wready_i : lsu_rvalid_i);
  assign lsu_skip = (lsu_state == S_IDLE) & (lsu_pend != '0) & cur.done;
  assign lsu_adv  = lsu_skip | lsu_done;

  always_comb begin
    lsu_state_nx = lsu_state;
    case (lsu_state)
      S_IDLE:  if (lsu_pend != '0 && !cur.done) lsu_state_nx = S_REQ;
      S_REQ:   if (lsu_done) lsu_state_nx = S_IDLE;
      default: lsu_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) lsu_state <= S_IDLE;
    else     lsu_state <= lsu_state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      head       <= '0;
      tail       <= '0;
      lsu_ptr    <= '0;
      count      <= '0;
      lsu_pend   <= '0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
    end else begin
      if (push) begin
        q[tail] <= new_entry;
        tail    <= tail + 1'b1;
      end
      // lsu_ptr never points at a free slot, so this never collides with the tail write
      if (lsu_done) begin
        q[lsu_ptr].done <= 1'b1;
        if (cur.kind == LOAD) q[lsu_ptr].result <= lsu_rdata_i;
      end
      if (pop)     head    <= head + 1'b1;
      if (lsu_adv) lsu_ptr <= lsu_ptr + 1'b1;
      count    <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      lsu_pend <= lsu_pend + {{PW{1'b0}}, push} - {{PW{1'b0}}, lsu_adv};
      redir_q  <= mispred;
      if (mispred) redir_pc_q <= actual;
    end
  end

  assign redirect_valid_o = redir_q;
  assign redirect_pc_o    = redir_pc_q;

  assign out_pc    = q[head].pc;
  assign out_rd    = q[head].rd;
  assign out_wdata = (q[head].rd == '0) ? '0 : q[head].result;

  assign lsu_avalid_o = (lsu_state == S_REQ);
  assign lsu_wen_o    = lsu_avalid_o & (cur.kind == STORE);
  assign lsu_addr_o   = lsu_avalid_o ? cur.addr   : '0;
  assign lsu_wdata_o  = lsu_avalid_o ? cur.wdata  : '0;
  assign lsu_funct3_o = lsu_avalid_o ? cur.funct3 : '0;

`ifdef YSYX_EXU_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_retire_o   <= '0;
      perf_mispred_o  <= '0;
      perf_lsu_wait_o <= '0;
    end else begin
      if (pop)                   perf_retire_o   <= perf_retire_o + 32'd1;
      if (redir_q)               perf_mispred_o  <= perf_mispred_o + 32'd1;
      if (lsu_state == S_REQ)    perf_lsu_wait_o <= perf_lsu_wait_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/ysyx_exu_cq.md
Name: ysyx_exu_cq

Overview:
Parametrised successor execution unit. It accepts decoded ops from the IDU into an in-order completion queue of DEPTH entries. ALU ops and branches resolve at issue. Loads and stores are serialised to the LSU without blocking the IDU. Entries retire strictly in order to WBU, and a branch redirect is raised on misprediction.

Parameters:
XLEN, 32, datapath/address width
DEPTH, 4, queue entries; power of 2, ≥2
RW, 4, register index width (4 = RV32E)

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  IDU op valid
in_ready  out  1  EXU can accept
in_kind  in  3  ALU/LOAD/STORE/BRANCH/JUMP (pkg enum)
in_alu_op  in  4  ALU op code (pkg)
in_src1, in_src2  in  XLEN  operands; src2 = store data for STORE
in_opj, in_imm  in  XLEN  address base / offset
in_funct3  in  3  memory size/sign, passed to LSU
in_pc, in_pnpc  in  XLEN  pc, predicted next pc
in_rd  in  RW  destination (0 = none)
lsu_avalid_o  out  1  LSU request
lsu_wen_o  out  1  1 = store
lsu_addr_o, lsu_wdata_o  out  XLEN  address, store data
lsu_funct3_o  out  3  size/sign
lsu_rdata_i  in  XLEN  load data, already extended
lsu_rvalid_i, lsu_wready_i  in  1  load/store completion
out_valid  out  1  head entry complete
out_ready  in  1  WBU accepts
out_pc, out_wdata  out  XLEN  retiring pc, rd data (0 if rd=0)
out_rd  out  RW  retiring rd
redirect_valid_o  out  1  one-cycle mispredict pulse
redirect_pc_o  out  XLEN  correct next pc

Behaviour:
- Reset is rst, synchronous, active-high, on clk.
- Reset values: queue empty; all pointers and count 0; in_ready=1; out_valid=0; lsu_avalid_o=0; redirect_valid_o=0; other outputs 0.
- Reset mid-LSU-transaction: the request is dropped and lsu_avalid_o=0 the next cycle. LSU responses arriving afterward are ignored until a new request is issued.
- Push condition: in_valid & in_ready. in_ready = (count<DEPTH) & ~redirect_valid_o.
- No same-cycle pop-to-push bypass when full.
- On push, an entry is written at the tail with pc, rd, kind, and done:
  - ALU: result = alu(src1,src2,op), done=1.
  - BRANCH: taken from the ALU compare (SUB→zero; XOR/SLT/SLTU/SLE/SLEU→nonzero). actual = taken ? opj+imm : pc+4. done=1, result=0.
  - JUMP: actual = opj+imm, result = pc+4, done=1.
  - LOAD/STORE: addr = opj+imm mod 2^XLEN. done=0.
- Mispredict is actual≠in_pnpc for BRANCH/JUMP. Next cycle: redirect_valid_o=1 for exactly one cycle with redirect_pc_o=actual, and in_ready=0 that cycle. Older entries are unaffected. The IDU discards younger ops.
- LSU FSM states IDLE→REQ→IDLE. lsu_ptr advances over done entries up to the tail.
  - IDLE: if entry[lsu_ptr] is an undone mem op, go to REQ and assert lsu_avalid_o with its fields.
  - REQ: hold all request signals stable until lsu_rvalid_i (load) or lsu_wready_i (store).
  - On completion: write rdata (load only), set done, return to IDLE. Fresh idle→request costs ≥1 cycle.
  - One outstanding request at most. Memory ops execute in program order.
- Pop: out_valid = count>0 & head.done. The pop on out_valid&out_ready advances head.
- Push, pop and LSU completion may coincide in one cycle. count = count + push − pop.
- Pointers are log2(DEPTH) bits and wrap naturally.

Optional Feature:
YSYX_EXU_PERF_EN
- Defined: adds outputs perf_retire_o, perf_mispred_o, perf_lsu_wait_o (each 32 b). Counts are pops, redirect pulses, and cycles in REQ respectively. Counters reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent, with no other change.

Decomposition:
- Package ysyx_exu_pkg holds:
  - kind_t enum (ALU=0, LOAD=1, STORE=2, BRANCH=3, JUMP=4)
  - ALU op localparams
  - cq_entry_t struct {pc, rd, kind, addr, wdata, funct3, result, done}
- Sub-module ysyx_exu_cq_alu: combinational XLEN-wide ALU plus branch-taken decode, shared by issue.
- Queue storage and LSU FSM stay in the top module.

Test Plan:
- Reset, then 3 ALU ADD ops (1+2, 5+7, 0+0 to rd=0) → retire in order; wdata 3, 12, 0; out_valid the cycle after each push.
- LOAD addr 0x80000010 then ALU op; LSU rvalid 5 cycles later with 0xDEADBEEF → ALU result held behind the load, load retires first with 0xDEADBEEF, then the ALU op.
- Fill DEPTH=4 with stores; wready held low → in_ready=0 after 4th push. One wready → one pop, in_ready=1 the next cycle.
- BEQ with src1=src2=7, opj=pc=0x100, imm=0x20, pnpc=0x104 → redirect_valid_o for one cycle, redirect_pc_o=0x120, in_ready=0 that cycle. Not-taken with pnpc=0x104 → no redirect.
- Assert rst while in REQ for a load → lsu_avalid_o=0 and queue empty next cycle. A stale rvalid afterward changes nothing.
- Push and pop simultaneously with count=DEPTH-1 every cycle for 20 cycles → count constant, no loss or duplication, and pointer wrap verified.
